// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED matrix framebuffer path: pixel and address
// widths derived from the panel geometry, plus the bank-swap FSM encoding.
package led_matrix_pkg;

  localparam int DEF_MATRIX_COLS = 96;
  localparam int DEF_MATRIX_ROWS = 48;
  localparam int DEF_PWM_BITS    = 4;
  localparam int DEF_FIFO_DEPTH  = 8;

  // One pixel carries red, green and blue, each PWM_BITS wide.
  function automatic int calc_pw(input int pwm_bits);
    return 3 * pwm_bits;
  endfunction

  // Pixel address width needed to cover every pixel of one bank.
  function automatic int calc_aw(input int cols, input int rows);
    return $clog2(cols * rows);
  endfunction

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

endpackage

// File: rtl/fb_write_fifo.sv
// Synchronous FIFO holding loader writes ({addr, data}) until the RAM port
// has an idle cycle. Pushes while full and pops while empty are ignored.
// The head entry is presented combinationally on pop_data.
module fb_write_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset because cnt gates visibility.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Owns the single-port double-banked framebuffer RAM. Scanner reads always
// win the port; loader writes queue in a FIFO and drain into the back bank
// on cycles the scanner leaves free. Bank swaps wait for a frame boundary
// with the FIFO empty so the panel never shows a half-written frame.
module fb_port_arbiter
  import led_matrix_pkg::*;
#(
  parameter  int MATRIX_COLS = DEF_MATRIX_COLS,
  parameter  int MATRIX_ROWS = DEF_MATRIX_ROWS,
  parameter  int PWM_BITS    = DEF_PWM_BITS,
  parameter  int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  localparam int AW          = calc_aw(MATRIX_COLS, MATRIX_ROWS),
  localparam int PW          = calc_pw(PWM_BITS)
) (
  input  logic          i_clk,
  input  logic          rst,
  input  logic          i_disp_req,
  input  logic [AW-1:0] i_disp_addr,
  output logic [PW-1:0] o_disp_data,
  output logic          o_disp_valid,
  input  logic          i_frame_end,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [PW-1:0] i_wr_data,
  input  logic          i_swap_req,
  output logic          o_swap_pending,
  output logic          o_swap_done,
  output logic          o_front_bank,
  output logic [AW:0]   o_mem_addr,
  output logic          o_mem_we,
  output logic [PW-1:0] o_mem_wdata,
  input  logic [PW-1:0] i_mem_rdata
);

  localparam int EW = AW + PW;

  logic                          fifo_push;
  logic                          fifo_pop;
  logic [EW-1:0]                 fifo_head;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic [AW-1:0]                 head_addr;
  logic [PW-1:0]                 head_data;

  logic [AW:0]                   last_addr_q;
  logic [PW-1:0]                 last_wdata_q;
  logic                          disp_valid_q;

  swap_state_e                   state_q;
  swap_state_e                   state_d;
  logic                          do_swap;
  logic                          front_q;
  logic                          swap_done_q;

  // New writes are refused while a swap waits, so the FIFO can only shrink
  // and the swap is guaranteed to find it empty eventually.
  assign o_wr_ready     = ~fifo_full & ~o_swap_pending;
  assign fifo_push      = i_wr_valid & o_wr_ready;
  assign fifo_pop       = ~i_disp_req & ~fifo_empty;
  assign head_addr      = fifo_head[EW-1:PW];
  assign head_data      = fifo_head[PW-1:0];

  assign o_disp_data    = i_mem_rdata;
  assign o_disp_valid   = disp_valid_q;
  assign o_front_bank   = front_q;
  assign o_swap_done    = swap_done_q;
  assign o_swap_pending = (state_q == SWAP_PENDING);

  fb_write_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({i_wr_addr, i_wr_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // RAM port mux: scanner read first, else drain one queued write into the
  // back bank, else leave the address and data lines where they were.
  always_comb begin
    o_mem_addr  = last_addr_q;
    o_mem_wdata = last_wdata_q;
    o_mem_we    = 1'b0;
    if (i_disp_req) begin
      o_mem_addr = {front_q, i_disp_addr};
    end else if (!fifo_empty) begin
      o_mem_addr  = {~front_q, head_addr};
      o_mem_wdata = head_data;
      o_mem_we    = 1'b1;
    end
  end

  // Remember the last driven address/data so idle cycles hold them, and
  // delay the read request by the RAM's one-cycle latency.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      last_addr_q  <= '0;
      last_wdata_q <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      last_addr_q  <= o_mem_addr;
      last_wdata_q <= o_mem_wdata;
      disp_valid_q <= i_disp_req;
    end
  end

  // Swap sequencing: a request arms the FSM; the swap itself happens only on
  // a frame end seen while no loader write is still queued for the back bank.
  always_comb begin
    state_d = state_q;
    do_swap = 1'b0;
    case (state_q)
      SWAP_IDLE: begin
        if (i_swap_req) begin
          state_d = SWAP_PENDING;
        end
      end
      SWAP_PENDING: begin
        if (i_frame_end && (fifo_count == '0)) begin
          state_d = SWAP_IDLE;
          do_swap = 1'b1;
        end
      end
      default: begin
        state_d = SWAP_IDLE;
      end
    endcase
  end

  // FSM state, front bank selector and the one-cycle swap-done pulse all
  // move on the same edge.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state_q     <= SWAP_IDLE;
      front_q     <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      swap_done_q <= do_swap;
      if (do_swap) begin
        front_q <= ~front_q;
      end
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: a table of single-cycle vectors
// for the port mux, then hand-written sequences for contention, bank swaps
// and reset in the middle of a burst.
module tb_fb_port_arbiter;

  localparam int AW = 13;
  localparam int PW = 12;

  logic          i_clk;
  logic          rst;
  logic          i_disp_req;
  logic [AW-1:0] i_disp_addr;
  logic [PW-1:0] o_disp_data;
  logic          o_disp_valid;
  logic          i_frame_end;
  logic          i_wr_valid;
  logic          o_wr_ready;
  logic [AW-1:0] i_wr_addr;
  logic [PW-1:0] i_wr_data;
  logic          i_swap_req;
  logic          o_swap_pending;
  logic          o_swap_done;
  logic          o_front_bank;
  logic [AW:0]   o_mem_addr;
  logic          o_mem_we;
  logic [PW-1:0] o_mem_wdata;
  logic [PW-1:0] i_mem_rdata;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_data;
    logic [PW-1:0] rdata;
    logic          exp_we;
    logic [AW:0]   exp_addr;
    logic [PW-1:0] exp_wdata;
    logic          exp_ready;
    logic          exp_dvalid;
    logic [PW-1:0] exp_ddata;
  } vec_t;

  vec_t vecs [18];

  fb_port_arbiter dut (
    .i_clk          (i_clk),
    .rst            (rst),
    .i_disp_req     (i_disp_req),
    .i_disp_addr    (i_disp_addr),
    .o_disp_data    (o_disp_data),
    .o_disp_valid   (o_disp_valid),
    .i_frame_end    (i_frame_end),
    .i_wr_valid     (i_wr_valid),
    .o_wr_ready     (o_wr_ready),
    .i_wr_addr      (i_wr_addr),
    .i_wr_data      (i_wr_data),
    .i_swap_req     (i_swap_req),
    .o_swap_pending (o_swap_pending),
    .o_swap_done    (o_swap_done),
    .o_front_bank   (o_front_bank),
    .o_mem_addr     (o_mem_addr),
    .o_mem_we       (o_mem_we),
    .o_mem_wdata    (o_mem_wdata),
    .i_mem_rdata    (i_mem_rdata)
  );

  // 100 MHz clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks happen on the falling edge.
  task automatic nextCycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    nextCycle();
    i_disp_req  = v.disp_req;
    i_disp_addr = v.disp_addr;
    i_wr_valid  = v.wr_valid;
    i_wr_addr   = v.wr_addr;
    i_wr_data   = v.wr_data;
    i_mem_rdata = v.rdata;
  endtask

  task automatic clearInputs();
    i_disp_req  = 1'b0;
    i_disp_addr = '0;
    i_wr_valid  = 1'b0;
    i_wr_addr   = '0;
    i_wr_data   = '0;
    i_swap_req  = 1'b0;
    i_frame_end = 1'b0;
    i_mem_rdata = '0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " mem_we"},       32'(o_mem_we),       32'h0);
    checkOutput({tag, " mem_addr"},     32'(o_mem_addr),     32'h0);
    checkOutput({tag, " mem_wdata"},    32'(o_mem_wdata),    32'h0);
    checkOutput({tag, " wr_ready"},     32'(o_wr_ready),     32'h1);
    checkOutput({tag, " disp_valid"},   32'(o_disp_valid),   32'h0);
    checkOutput({tag, " swap_pending"}, 32'(o_swap_pending), 32'h0);
    checkOutput({tag, " swap_done"},    32'(o_swap_done),    32'h0);
    checkOutput({tag, " front_bank"},   32'(o_front_bank),   32'h0);
  endtask

  initial begin
    int accepted;
    int we_seen;

    // disp_req, disp_addr, wr_valid, wr_addr, wr_data, rdata |
    // we, addr, wdata, ready, dvalid, ddata
    vecs[0]  = '{1'b0, 13'h0000, 1'b0, 13'h0000, 12'h000, 12'h000, 1'b0, 14'h0000, 12'h000, 1'b1, 1'b0, 12'h000};
    vecs[1]  = '{1'b0, 13'h0000, 1'b1, 13'h0000, 12'h0A0, 12'h000, 1'b0, 14'h0000, 12'h000, 1'b1, 1'b0, 12'h000};
    vecs[2]  = '{1'b0, 13'h0000, 1'b1, 13'h0001, 12'h0A1, 12'h000, 1'b1, 14'h2000, 12'h0A0, 1'b1, 1'b0, 12'h000};
    vecs[3]  = '{1'b0, 13'h0000, 1'b1, 13'h0002, 12'h0A2, 12'h000, 1'b1, 14'h2001, 12'h0A1, 1'b1, 1'b0, 12'h000};
    vecs[4]  = '{1'b0, 13'h0000, 1'b1, 13'h0003, 12'h0A3, 12'h000, 1'b1, 14'h2002, 12'h0A2, 1'b1, 1'b0, 12'h000};
    vecs[5]  = '{1'b0, 13'h0000, 1'b1, 13'h0004, 12'h0A4, 12'h000, 1'b1, 14'h2003, 12'h0A3, 1'b1, 1'b0, 12'h000};
    vecs[6]  = '{1'b0, 13'h0000, 1'b1, 13'h0005, 12'h0A5, 12'h000, 1'b1, 14'h2004, 12'h0A4, 1'b1, 1'b0, 12'h000};
    vecs[7]  = '{1'b0, 13'h0000, 1'b1, 13'h0006, 12'h0A6, 12'h000, 1'b1, 14'h2005, 12'h0A5, 1'b1, 1'b0, 12'h000};
    vecs[8]  = '{1'b0, 13'h0000, 1'b1, 13'h0007, 12'h0A7, 12'h000, 1'b1, 14'h2006, 12'h0A6, 1'b1, 1'b0, 12'h000};
    vecs[9]  = '{1'b0, 13'h0000, 1'b0, 13'h0000, 12'h000, 12'h000, 1'b1, 14'h2007, 12'h0A7, 1'b1, 1'b0, 12'h000};
    vecs[10] = '{1'b0, 13'h0000, 1'b0, 13'h0000, 12'h000, 12'h000, 1'b0, 14'h2007, 12'h0A7, 1'b1, 1'b0, 12'h000};
    vecs[11] = '{1'b1, 13'h0005, 1'b0, 13'h0000, 12'h000, 12'h123, 1'b0, 14'h0005, 12'h0A7, 1'b1, 1'b0, 12'h123};
    vecs[12] = '{1'b1, 13'h1FFF, 1'b0, 13'h0000, 12'h000, 12'h456, 1'b0, 14'h1FFF, 12'h0A7, 1'b1, 1'b1, 12'h456};
    vecs[13] = '{1'b0, 13'h0000, 1'b0, 13'h0000, 12'h000, 12'hABC, 1'b0, 14'h1FFF, 12'h0A7, 1'b1, 1'b1, 12'hABC};
    vecs[14] = '{1'b0, 13'h0000, 1'b0, 13'h0000, 12'h000, 12'h000, 1'b0, 14'h1FFF, 12'h0A7, 1'b1, 1'b0, 12'h000};
    vecs[15] = '{1'b1, 13'h0003, 1'b1, 13'h0010, 12'h555, 12'h000, 1'b0, 14'h0003, 12'h0A7, 1'b1, 1'b0, 12'h000};
    vecs[16] = '{1'b0, 13'h0000, 1'b0, 13'h0000, 12'h000, 12'h000, 1'b1, 14'h2010, 12'h555, 1'b1, 1'b1, 12'h000};
    vecs[17] = '{1'b0, 13'h0000, 1'b0, 13'h0000, 12'h000, 12'h000, 1'b0, 14'h2010, 12'h555, 1'b1, 1'b0, 12'h000};

    clearInputs();
    rst = 1'b1;
    repeat (2) @(posedge i_clk);
    sample();
    checkResetValues("reset");
    nextCycle();
    rst = 1'b0;

    // Port mux table: write burst into bank 1, reads, read/write overlap.
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      sample();
      checkOutput($sformatf("vec%0d mem_we", i),     32'(o_mem_we),     32'(vecs[i].exp_we));
      checkOutput($sformatf("vec%0d mem_addr", i),   32'(o_mem_addr),   32'(vecs[i].exp_addr));
      checkOutput($sformatf("vec%0d mem_wdata", i),  32'(o_mem_wdata),  32'(vecs[i].exp_wdata));
      checkOutput($sformatf("vec%0d wr_ready", i),   32'(o_wr_ready),   32'(vecs[i].exp_ready));
      checkOutput($sformatf("vec%0d disp_valid", i), 32'(o_disp_valid), 32'(vecs[i].exp_dvalid));
      checkOutput($sformatf("vec%0d disp_data", i),  32'(o_disp_data),  32'(vecs[i].exp_ddata));
    end
    clearInputs();

    // Contention: scanner holds the port for 20 cycles while the loader
    // offers 10 writes; only FIFO_DEPTH fit and none reach the RAM.
    accepted = 0;
    we_seen  = 0;
    for (int c = 0; c < 20; c++) begin
      nextCycle();
      i_disp_req  = 1'b1;
      i_disp_addr = 13'(c);
      i_wr_valid  = (c < 10);
      i_wr_addr   = 13'(32'h100 + accepted);
      i_wr_data   = 12'(32'h300 + accepted);
      sample();
      if (i_wr_valid && o_wr_ready) accepted++;
      if (o_mem_we) we_seen++;
    end
    checkOutput("contention accepted", 32'(accepted), 32'd8);
    checkOutput("contention writes",   32'(we_seen),  32'd0);
    checkOutput("contention ready",    32'(o_wr_ready), 32'h0);
    nextCycle();
    clearInputs();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) nextCycle();
      sample();
      checkOutput($sformatf("drain%0d we", i),    32'(o_mem_we),    32'h1);
      checkOutput($sformatf("drain%0d addr", i),  32'(o_mem_addr),  32'h2000 | (32'h100 + i));
      checkOutput($sformatf("drain%0d wdata", i), 32'(o_mem_wdata), 32'h300 + i);
      if (i == 0) checkOutput("drain0 ready (full+pop)", 32'(o_wr_ready), 32'h0);
      if (i == 1) checkOutput("drain1 ready",            32'(o_wr_ready), 32'h1);
    end
    nextCycle();
    sample();
    checkOutput("drain done we", 32'(o_mem_we), 32'h0);

    // Swap with an empty FIFO: request, then frame end five cycles later.
    nextCycle();
    i_swap_req = 1'b1;
    sample();
    checkOutput("swap req pending not yet", 32'(o_swap_pending), 32'h0);
    nextCycle();
    i_swap_req = 1'b0;
    sample();
    checkOutput("swap pending",       32'(o_swap_pending), 32'h1);
    checkOutput("swap pending ready", 32'(o_wr_ready),     32'h0);
    repeat (4) begin
      nextCycle();
      sample();
    end
    checkOutput("swap front before", 32'(o_front_bank), 32'h0);
    nextCycle();
    i_frame_end = 1'b1;
    sample();
    checkOutput("swap done before edge", 32'(o_swap_done), 32'h0);
    nextCycle();
    i_frame_end = 1'b0;
    sample();
    checkOutput("swap done pulse",   32'(o_swap_done),    32'h1);
    checkOutput("swap front after",  32'(o_front_bank),   32'h1);
    checkOutput("swap pending clr",  32'(o_swap_pending), 32'h0);
    nextCycle();
    i_disp_req  = 1'b1;
    i_disp_addr = 13'h0007;
    sample();
    checkOutput("swap done pulse end", 32'(o_swap_done), 32'h0);
    checkOutput("swap read bank1",     32'(o_mem_addr),  32'h2007);
    nextCycle();
    clearInputs();
    sample();
    checkOutput("swap read valid", 32'(o_disp_valid), 32'h1);

    // Swap blocked: three writes stuck behind the scanner at frame end.
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      i_disp_req  = 1'b1;
      i_disp_addr = 13'(i);
      i_wr_valid  = 1'b1;
      i_wr_addr   = 13'(32'h20 + i);
      i_wr_data   = 12'(32'h700 + i);
      sample();
      checkOutput($sformatf("blocked push%0d we", i), 32'(o_mem_we), 32'h0);
    end
    nextCycle();
    i_wr_valid = 1'b0;
    i_swap_req = 1'b1;
    nextCycle();
    i_swap_req = 1'b0;
    nextCycle();
    i_frame_end = 1'b1;
    nextCycle();
    i_frame_end = 1'b0;
    sample();
    checkOutput("blocked no done",  32'(o_swap_done),    32'h0);
    checkOutput("blocked front",    32'(o_front_bank),   32'h1);
    checkOutput("blocked pending",  32'(o_swap_pending), 32'h1);
    nextCycle();
    i_disp_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) nextCycle();
      sample();
      checkOutput($sformatf("blocked drain%0d we", i),    32'(o_mem_we),    32'h1);
      checkOutput($sformatf("blocked drain%0d addr", i),  32'(o_mem_addr),  32'h20 + i);
      checkOutput($sformatf("blocked drain%0d wdata", i), 32'(o_mem_wdata), 32'h700 + i);
    end
    nextCycle();
    i_frame_end = 1'b1;
    sample();
    checkOutput("blocked drained we", 32'(o_mem_we), 32'h0);
    nextCycle();
    i_frame_end = 1'b0;
    sample();
    checkOutput("blocked 2nd done",    32'(o_swap_done),    32'h1);
    checkOutput("blocked 2nd front",   32'(o_front_bank),   32'h0);
    checkOutput("blocked 2nd pending", 32'(o_swap_pending), 32'h0);

    // Request and frame end together: arm only, swap at the next frame end.
    nextCycle();
    i_swap_req  = 1'b1;
    i_frame_end = 1'b1;
    nextCycle();
    i_swap_req  = 1'b0;
    i_frame_end = 1'b0;
    sample();
    checkOutput("simul pending", 32'(o_swap_pending), 32'h1);
    checkOutput("simul no done", 32'(o_swap_done),    32'h0);
    repeat (3) begin
      nextCycle();
      sample();
    end
    checkOutput("simul front held", 32'(o_front_bank), 32'h0);
    nextCycle();
    i_frame_end = 1'b1;
    nextCycle();
    i_frame_end = 1'b0;
    sample();
    checkOutput("simul done",  32'(o_swap_done),  32'h1);
    checkOutput("simul front", 32'(o_front_bank), 32'h1);

    // Reset mid-burst: five writes queued and a swap pending.
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      i_disp_req = 1'b1;
      i_wr_valid = 1'b1;
      i_wr_addr  = 13'(32'h40 + i);
      i_wr_data  = 12'(32'h800 + i);
    end
    nextCycle();
    i_wr_valid = 1'b0;
    i_swap_req = 1'b1;
    nextCycle();
    i_swap_req = 1'b0;
    sample();
    checkOutput("prerst pending", 32'(o_swap_pending), 32'h1);
    checkOutput("prerst valid",   32'(o_disp_valid),   32'h1);
    nextCycle();
    clearInputs();
    rst = 1'b1;
    sample();
    checkResetValues("midrst");
    nextCycle();
    rst = 1'b0;
    sample();
    checkResetValues("postrst");
    nextCycle();
    sample();
    checkOutput("postrst fifo empty", 32'(o_mem_we), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
